cache_l2_direct_param: RTL and testbench
========================================

# cache_l2_direct_param

Parametrised direct-mapped L2 cache. It sits between the L1 miss path and main memory. It serves L1 read requests with a wrapping multi-word burst and refills missed lines critical-word-first from memory over a valid/ready handshake. Writes are write-through, no-allocate. The block updates its copy on a hit, and the memory-side write path is handled outside this block.

## Interface
Parameters:
- ADDR_W, 32: word address width; addresses are word-addressed.
- DATA_W, 32: word width.
- INDEX_W, 3: set index bits; the cache has 2^INDEX_W lines.
- OFFSET_W, 3: word-offset bits; a line holds 2^OFFSET_W words.
- L1_BURST, 4: words returned per read; 1 ≤ L1_BURST ≤ 2^OFFSET_W.
- CNT_W, 16: width of the hit and miss counters.

Ports (clk/rst: one clock; reset is synchronous and active-high):
- clk  in  1  clock; everything is sampled on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  L1 request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address: tag = [ADDR_W-1:INDEX_W+OFFSET_W], index = [INDEX_W+OFFSET_W-1:OFFSET_W], offset = [OFFSET_W-1:0].
- req_wdata  in  DATA_W  write data.
- resp_valid  out  1  read data word valid.
- resp_data  out  DATA_W  read data word.
- resp_last  out  1  marks the final word of the burst.
- mem_req_valid  out  1  refill request to memory.
- mem_req_ready  in  1  memory accepts the refill request.
- mem_req_addr  out  ADDR_W  address of the missed word (critical word first).
- mem_rvalid  in  1  refill word valid.
- mem_rdata  in  DATA_W  refill word.
- hit_count  out  CNT_W  count of read hits; saturates at its maximum.
- miss_count  out  CNT_W  count of read misses; saturates at its maximum.

## Operation
- Storage: per line, one valid bit, a tag, and 2^OFFSET_W data words. A request is accepted when req_valid & req_ready are both high.
- hit = valid[index] & (stored tag == request tag), evaluated in the accept cycle.
- FSM states: IDLE, MREQ, REFILL, SEND.
- IDLE, write accepted:
  - On a hit, data[index][offset] <= req_wdata.
  - On a miss, nothing changes.
  - Stays in IDLE; writes produce no response.
- IDLE, read accepted:
  - The block latches index, tag, offset, and a word pointer k = 0.
  - On a hit: hit_count increments (saturating), then go to SEND.
  - On a miss: miss_count increments (saturating), valid[index] <= 0, then go to MREQ.
- MREQ:
  - mem_req_valid = 1 and mem_req_addr = the latched request address.
  - Go to REFILL on mem_req_ready.
- REFILL:
  - For each mem_rvalid, write the word to data[index][(offset+k) mod 2^OFFSET_W], then k++.
  - Gaps in mem_rvalid are tolerated.
  - After word 2^OFFSET_W: valid <= 1, the tag is written, k <= 0, then go to SEND.
- SEND:
  - Each cycle, resp_valid = 1 and resp_data = data[index][(offset+k) mod 2^OFFSET_W], then k++.
  - resp_last = 1 when k == L1_BURST-1; the next state is IDLE.
  - L1 cannot stall the burst.
- Offset arithmetic is OFFSET_W bits wide and wraps naturally.
- Counters are CNT_W bits wide and hold at all-ones.

## Timing
- Reset values:
  - State IDLE, all valid bits 0, k = 0.
  - req_ready = 1; resp_valid, resp_last, mem_req_valid = 0.
  - resp_data, mem_req_addr = 0; hit_count, miss_count = 0.
  - Data and tag arrays are not reset.
- Read hit accepted in cycle N: response words appear in cycles N+1 … N+L1_BURST, with resp_last in cycle N+L1_BURST. req_ready returns high in cycle N+L1_BURST+1.
- Read miss accepted in cycle N: mem_req_valid is high from N+1 until the handshake.
  - mem_rvalid is sampled from the cycle after the handshake.
  - If the last refill word arrives in cycle M, the first response word appears in M+1.
- All outputs are registered or decoded from state. There is no combinational path from inputs to outputs, except req_ready, which depends on state only.
- Reset mid-operation (MREQ, REFILL, or SEND):
  - The FSM returns to IDLE on the next edge and the burst is abandoned.
  - A partially refilled line stays invalid, because valid was cleared at miss acceptance.
- Requests are never accepted outside IDLE (req_ready = 0). A write to the line being refilled is impossible.

## Test plan
All scenarios use default parameters. Refill words are 0xA0+i for the word at offset i, unless stated otherwise.
1. Cold miss: rst, then read 0x48 (tag 1, index 1, offset 0).
   - mem_req_addr = 0x48.
   - Feed the refill 0xA0..0xA7.
   - Expect resp 0xA0, 0xA1, 0xA2, 0xA3, last on 0xA3; miss_count = 1.
2. Wrapping hit: read 0x4E after scenario 1.
   - No mem_req_valid.
   - Expect resp 0xA6, 0xA7, 0xA0, 0xA1 in cycles N+1..N+4; hit_count = 1.
3. Critical-word-first refill: read 0x5C (index 3, offset 4).
   - Refill words arrive for offsets 4, 5, 6, 7, 0, 1, 2, 3, with 2-cycle gaps.
   - A following read of 0x58 hits and returns words in offset order 0..3.
4. Writes:
   - Write 0x4A with 0xDEADBEEF (hit), then read 0x48 → 0xA0, 0xA1, 0xDEADBEEF, 0xA3.
   - Write 0x88 (miss) causes no change; read 0x48 still hits.
5. Conflict and reset mid-refill:
   - Read 0x88 → miss; refill replaces index 1; read 0x48 → miss.
   - During that refill, assert rst after 3 words. req_ready is high the next cycle, counters are 0, and read 0x48 misses again.

Source files
------------

// File: rtl/cache_l2_direct_param.sv
// Direct-mapped L2 cache between the L1 miss path and main memory.
// Reads return a wrapping burst of L1_BURST words starting at the requested
// offset. Read misses refill the whole line from memory, critical word first.
// Writes are write-through and do not allocate: a write hit updates the
// local copy, and a write miss leaves the cache unchanged. The memory-side
// write is performed outside this block.
// All outputs are registered or decoded from state. The one exception is
// req_ready, which depends on state only.
module cache_l2_direct_param #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int INDEX_W  = 3,
    parameter int OFFSET_W = 3,
    parameter int L1_BURST = 4,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_last,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int LINES = 1 << INDEX_W;
    localparam int WORDS = 1 << OFFSET_W;
    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LA_W  = INDEX_W + OFFSET_W;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] MREQ   = 2'd1;
    localparam logic [1:0] REFILL = 2'd2;
    localparam logic [1:0] SEND   = 2'd3;

    // Word pointer landmarks: the last refill word, the last burst beat, and
    // the pointer value used once beat 0 has already been loaded.
    localparam logic [OFFSET_W-1:0] K_LAST_WORD = {OFFSET_W{1'b1}};
    localparam logic [OFFSET_W-1:0] K_LAST_BEAT = OFFSET_W'(L1_BURST - 1);
    localparam logic [OFFSET_W-1:0] K_ONE       = OFFSET_W'(1);
    localparam logic [CNT_W-1:0]    CNT_MAX     = {CNT_W{1'b1}};
    localparam logic                BURST_ONE   = (L1_BURST == 1);

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [LINES-1:0]  valid_reg;
    logic [LINES-1:0]  valid_next;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES*WORDS];

    // ------------------------------------------------------------------
    // Transaction state
    // ------------------------------------------------------------------
    logic [1:0]          state_reg;
    logic [INDEX_W-1:0]  index_reg;
    logic [TAG_W-1:0]    tag_reg;
    logic [OFFSET_W-1:0] offset_reg;
    logic [OFFSET_W-1:0] k_reg;

    logic                resp_valid_reg;
    logic                resp_last_reg;
    logic [DATA_W-1:0]   resp_data_reg;
    logic                mem_req_valid_reg;
    logic [ADDR_W-1:0]   mem_req_addr_reg;
    logic [CNT_W-1:0]    hit_count_reg;
    logic [CNT_W-1:0]    miss_count_reg;

    // ------------------------------------------------------------------
    // Request decode and lookup
    // ------------------------------------------------------------------
    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  req_index;
    logic [OFFSET_W-1:0] req_offset;
    logic                accept;
    logic                lookup_hit;
    logic                rd_hit;
    logic                rd_miss;
    logic                wr_hit;
    logic                refill_beat;
    logic                refill_done;
    logic                send_step;
    logic                load_word;
    logic [OFFSET_W-1:0] ptr_off;
    logic [LA_W-1:0]     rd_addr;
    logic [LA_W-1:0]     wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic                mem_we;
    logic                bypass;

    assign req_tag    = req_addr[ADDR_W-1:LA_W];
    assign req_index  = req_addr[LA_W-1:OFFSET_W];
    assign req_offset = req_addr[OFFSET_W-1:0];

    assign req_ready  = (state_reg == IDLE);
    assign accept     = req_valid & req_ready;
    assign lookup_hit = valid_reg[req_index] & (tag_mem[req_index] == req_tag);
    assign rd_hit     = accept & ~req_write & lookup_hit;
    assign rd_miss    = accept & ~req_write & ~lookup_hit;
    assign wr_hit     = accept & req_write & lookup_hit;

    // Refill and burst walk the same wrapping pointer through the line.
    // Because the pointer is OFFSET_W bits wide, the wrap is implicit.
    assign ptr_off     = offset_reg + k_reg;
    assign refill_beat = (state_reg == REFILL) & mem_rvalid;
    assign refill_done = refill_beat & (k_reg == K_LAST_WORD);
    assign send_step   = (state_reg == SEND) & ~resp_last_reg;
    assign load_word   = rd_hit | refill_done | send_step;

    // Read address for the response register. On a hit, the first beat
    // comes straight from the request fields. On refill completion, it is
    // the critical word. Otherwise the burst walks the pointer.
    always_comb begin
        rd_addr = {index_reg, ptr_off};
        if (state_reg == IDLE) begin
            rd_addr = {req_index, req_offset};
        end else if (state_reg == REFILL) begin
            rd_addr = {index_reg, offset_reg};
        end
    end

    // Single write port, shared by write hits in IDLE and by refill beats.
    always_comb begin
        wr_addr = {index_reg, ptr_off};
        wr_data = mem_rdata;
        if (state_reg == IDLE) begin
            wr_addr = {req_index, req_offset};
            wr_data = req_wdata;
        end
    end

    assign mem_we = ~rst & (wr_hit | refill_beat);

    // With a one-word line, the critical word arrives on the same edge that
    // loads it for the response. In that case it must bypass the array.
    assign bypass = refill_done & (rd_addr == wr_addr);

    // Data array write port (array is deliberately not reset)
    always_ff @(posedge clk) begin
        if (mem_we) begin
            data_mem[wr_addr] <= wr_data;
        end
    end

    // Tag written once the whole line has arrived
    always_ff @(posedge clk) begin
        if (~rst & refill_done) begin
            tag_mem[index_reg] <= tag_reg;
        end
    end

    // Per-line valid update. A line is invalidated when a read misses on it,
    // so an abandoned refill leaves it invalid. It is set again only after
    // the final refill word.
    genvar gi;
    generate
        for (gi = 0; gi < LINES; gi++) begin : g_valid
            assign valid_next[gi] =
                (rd_miss && (req_index == INDEX_W'(gi))) ? 1'b0 :
                (refill_done && (index_reg == INDEX_W'(gi))) ? 1'b1 :
                valid_reg[gi];
        end
    endgenerate

    // Valid bit register bank
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= '0;
        end else begin
            valid_reg <= valid_next;
        end
    end

    // Main controller: accept, memory request, refill and burst sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= IDLE;
            index_reg         <= '0;
            tag_reg           <= '0;
            offset_reg        <= '0;
            k_reg             <= '0;
            resp_valid_reg    <= 1'b0;
            resp_last_reg     <= 1'b0;
            mem_req_valid_reg <= 1'b0;
            mem_req_addr_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept && !req_write) begin
                        index_reg  <= req_index;
                        tag_reg    <= req_tag;
                        offset_reg <= req_offset;
                        if (lookup_hit) begin
                            // Beat 0 is loaded on this edge, so the pointer
                            // moves straight to beat 1.
                            state_reg      <= SEND;
                            k_reg          <= K_ONE;
                            resp_valid_reg <= 1'b1;
                            resp_last_reg  <= BURST_ONE;
                        end else begin
                            state_reg         <= MREQ;
                            k_reg             <= '0;
                            mem_req_valid_reg <= 1'b1;
                            mem_req_addr_reg  <= req_addr;
                        end
                    end
                end
                MREQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid_reg <= 1'b0;
                        state_reg         <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem_rvalid) begin
                        if (k_reg == K_LAST_WORD) begin
                            state_reg      <= SEND;
                            k_reg          <= K_ONE;
                            resp_valid_reg <= 1'b1;
                            resp_last_reg  <= BURST_ONE;
                        end else begin
                            k_reg <= k_reg + K_ONE;
                        end
                    end
                end
                SEND: begin
                    if (resp_last_reg) begin
                        state_reg      <= IDLE;
                        resp_valid_reg <= 1'b0;
                        resp_last_reg  <= 1'b0;
                        k_reg          <= '0;
                    end else begin
                        resp_last_reg <= (k_reg == K_LAST_BEAT);
                        k_reg         <= k_reg + K_ONE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Registered array read feeding the response data output
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_data_reg <= '0;
        end else if (load_word) begin
            resp_data_reg <= bypass ? mem_rdata : data_mem[rd_addr];
        end
    end

    // Saturating hit/miss statistics, counted for reads only
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
        end else begin
            if (rd_hit && hit_count_reg != CNT_MAX) begin
                hit_count_reg <= hit_count_reg + 1'b1;
            end
            if (rd_miss && miss_count_reg != CNT_MAX) begin
                miss_count_reg <= miss_count_reg + 1'b1;
            end
        end
    end

    assign resp_valid    = resp_valid_reg;
    assign resp_data     = resp_data_reg;
    assign resp_last     = resp_last_reg;
    assign mem_req_valid = mem_req_valid_reg;
    assign mem_req_addr  = mem_req_addr_reg;
    assign hit_count     = hit_count_reg;
    assign miss_count    = miss_count_reg;

endmodule

// File: tb/tb_cache_l2_direct_param.sv
// Directed bench for cache_l2_direct_param using the default parameters.
// A line-level cache model tracks valid/tag/data per set and the expected
// response words and the cycle of each. A negedge compare process checks the
// DUT against this model every cycle. Literal expectations pin key bursts
// and counter values.
module tb_cache_l2_direct_param;

    localparam int WORDS    = 8;
    localparam int LINES    = 8;
    localparam int BURST    = 4;
    localparam int CNT_MAXV = 65535;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_last;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    cache_l2_direct_param dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_last(resp_last),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- model ----------------
    typedef struct {
        logic [31:0] data;
        bit          last;
        int          cyc;
    } exp_t;

    bit          m_valid [LINES];
    int          m_tag   [LINES];
    logic [31:0] m_data  [LINES][WORDS];
    int          m_hits;
    int          m_misses;
    exp_t        exp_q[$];
    exp_t        cmp_e;
    bit          exp_busy;
    bit          exp_mreq;
    logic [31:0] exp_maddr;
    bit          chk_en = 1'b0;

    logic [31:0] cap [8];
    int          cap_n;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
        m_hits   = 0;
        m_misses = 0;
        exp_q.delete();
        exp_busy = 1'b0;
        exp_mreq = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 50 && !req_ready; i++) tick();
        check("ready_timeout", 64'(req_ready), 64'(1));
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (exp_q.size() != 0 || exp_busy); i++) tick();
        if (exp_q.size() != 0 || exp_busy) begin
            check("drain_timeout", 64'(exp_q.size()), 64'(0));
            exp_q.delete();
            exp_busy = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0;
    endtask

    // Read at addr. On a miss, memory holds off mem_req_ready for 'stall'
    // cycles, then returns base+offset for each word with 'gap' idle cycles
    // before each word. Reset is applied once stop_after words have arrived.
    task automatic do_read(input logic [31:0] addr, input int stall, input int gap,
                           input logic [31:0] base, input int stop_after);
        int  n, m, idx, off, tag, o;
        bit  hit;
        wait_ready();
        cap_n = 0;
        idx = int'((addr >> 3) & 32'd7);
        off = int'(addr & 32'd7);
        tag = int'(addr >> 6);
        n = cyc;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = addr;
        @(posedge clk);
        hit = m_valid[idx] && (m_tag[idx] == tag);
        exp_busy = 1'b1;
        if (hit) begin
            if (m_hits < CNT_MAXV) m_hits++;
            for (int i = 0; i < BURST; i++)
                exp_q.push_back('{m_data[idx][(off + i) % WORDS], i == BURST - 1, n + 1 + i});
        end else begin
            if (m_misses < CNT_MAXV) m_misses++;
            m_valid[idx] = 1'b0;
            exp_mreq  = 1'b1;
            exp_maddr = addr;
        end
        #1;
        req_valid = 1'b0;
        if (!hit) begin
            for (int s = 0; s < stall; s++) tick();
            mem_req_ready = 1'b1;
            @(posedge clk);
            exp_mreq = 1'b0;
            #1;
            mem_req_ready = 1'b0;
            m = cyc;
            for (int i = 0; i < WORDS; i++) begin
                if (i == stop_after) begin
                    do_reset();
                    return;
                end
                for (int g = 0; g < gap; g++) tick();
                o = (off + i) % WORDS;
                mem_rvalid = 1'b1;
                mem_rdata  = base + 32'(o);
                m = cyc;
                @(posedge clk);
                m_data[idx][o] = base + 32'(o);
                #1;
                mem_rvalid = 1'b0;
            end
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tag;
            for (int i = 0; i < BURST; i++)
                exp_q.push_back('{m_data[idx][(off + i) % WORDS], i == BURST - 1, m + 1 + i});
        end
        drain();
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] wdata);
        int idx, off, tag;
        wait_ready();
        idx = int'((addr >> 3) & 32'd7);
        off = int'(addr & 32'd7);
        tag = int'(addr >> 6);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        if (m_valid[idx] && m_tag[idx] == tag) m_data[idx][off] = wdata;
        #1;
        req_valid = 1'b0;
        req_write = 1'b0;
        tick();
    endtask

    task automatic check_burst(input string name, input logic [31:0] w0, input logic [31:0] w1,
                               input logic [31:0] w2, input logic [31:0] w3);
        check({name, "_n"}, 64'(cap_n), 64'(4));
        check({name, "_w0"}, 64'(cap[0]), 64'(w0));
        check({name, "_w1"}, 64'(cap[1]), 64'(w1));
        check({name, "_w2"}, 64'(cap[2]), 64'(w2));
        check({name, "_w3"}, 64'(cap[3]), 64'(w3));
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("req_ready", 64'(req_ready), 64'(!exp_busy));
            check("mem_req_valid", 64'(mem_req_valid), 64'(exp_mreq));
            if (exp_mreq) check("mem_req_addr", 64'(mem_req_addr), 64'(exp_maddr));
            if (req_ready) begin
                check("hit_count", 64'(hit_count), 64'(m_hits));
                check("miss_count", 64'(miss_count), 64'(m_misses));
            end
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    check("resp_spurious", 64'(resp_data), 64'(0));
                    if (resp_data == 32'd0) begin
                        errors++;
                        $display("FAIL resp_spurious_zero: got resp_valid=1 expected 0 (cycle %0d)", cyc);
                    end
                end else begin
                    cmp_e = exp_q.pop_front();
                    check("resp_data", 64'(resp_data), 64'(cmp_e.data));
                    check("resp_last", 64'(resp_last), 64'(cmp_e.last));
                    check("resp_cycle", 64'(cyc), 64'(cmp_e.cyc));
                    if (cap_n < 8) cap[cap_n] = resp_data;
                    cap_n++;
                    if (cmp_e.last) exp_busy = 1'b0;
                end
            end else if (exp_q.size() != 0 && cyc >= exp_q[0].cyc) begin
                check("resp_missing", 64'(resp_valid), 64'(1));
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) tick();
        rst = 1'b0;
        // Reset state
        check("rst_req_ready", 64'(req_ready), 64'(1));
        check("rst_resp_valid", 64'(resp_valid), 64'(0));
        check("rst_resp_last", 64'(resp_last), 64'(0));
        check("rst_resp_data", 64'(resp_data), 64'(0));
        check("rst_mem_req_valid", 64'(mem_req_valid), 64'(0));
        check("rst_mem_req_addr", 64'(mem_req_addr), 64'(0));
        check("rst_hit_count", 64'(hit_count), 64'(0));
        check("rst_miss_count", 64'(miss_count), 64'(0));
        chk_en = 1'b1;

        // 1. Cold miss with a stalled memory handshake
        do_read(32'h48, 2, 0, 32'hA0, WORDS);
        check_burst("s1", 32'hA0, 32'hA1, 32'hA2, 32'hA3);
        check("s1_miss_count", 64'(miss_count), 64'(1));
        check("s1_hit_count", 64'(hit_count), 64'(0));

        // 2. Wrapping hit
        do_read(32'h4E, 0, 0, 32'h0, WORDS);
        check_burst("s2", 32'hA6, 32'hA7, 32'hA0, 32'hA1);
        check("s2_hit_count", 64'(hit_count), 64'(1));

        // 3. Critical-word-first refill with gaps, then an in-order hit
        do_read(32'h5C, 0, 2, 32'hA0, WORDS);
        check_burst("s3_miss", 32'hA4, 32'hA5, 32'hA6, 32'hA7);
        do_read(32'h58, 0, 0, 32'h0, WORDS);
        check_burst("s3_hit", 32'hA0, 32'hA1, 32'hA2, 32'hA3);
        check("s3_counts", 64'({hit_count, miss_count}), 64'({16'd2, 16'd2}));

        // 4. Write hit updates the line; write miss changes nothing
        do_write(32'h4A, 32'hDEADBEEF);
        do_read(32'h48, 0, 0, 32'h0, WORDS);
        check_burst("s4_wr_hit", 32'hA0, 32'hA1, 32'hDEADBEEF, 32'hA3);
        do_write(32'h88, 32'h12345678);
        do_read(32'h48, 0, 0, 32'h0, WORDS);
        check_burst("s4_wr_miss", 32'hA0, 32'hA1, 32'hDEADBEEF, 32'hA3);
        check("s4_hit_count", 64'(hit_count), 64'(4));

        // 5. Conflict replacement, then reset part-way through a refill
        do_read(32'h88, 0, 1, 32'hB0, WORDS);
        check_burst("s5_conflict", 32'hB0, 32'hB1, 32'hB2, 32'hB3);
        check("s5_miss_count", 64'(miss_count), 64'(3));
        do_read(32'h48, 0, 0, 32'hA0, 3);
        check("s5_ready_after_rst", 64'(req_ready), 64'(1));
        check("s5_counts_after_rst", 64'({hit_count, miss_count}), 64'(0));
        do_read(32'h48, 1, 0, 32'hA0, WORDS);
        check_burst("s5_refetch", 32'hA0, 32'hA1, 32'hA2, 32'hA3);
        check("s5_refetch_counts", 64'({hit_count, miss_count}), 64'({16'd0, 16'd1}));

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
